mem_request_arbiter: RTL and testbench
======================================

MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning the fixed read latency of the cache controller from raddr_valid to rdata, in cycles.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 if_rreq_valid / if_rreq_ready  input / output  1 / 1  instruction-fetch read request handshake.
REQ-006 if_rreq_addr  input  ADDR_W  instruction-fetch read address.
REQ-007 ls_rreq_valid / ls_rreq_ready  input / output  1 / 1  load/store read request handshake.
REQ-008 ls_rreq_addr  input  ADDR_W  load/store read address.
REQ-009 ls_wreq_valid / ls_wreq_ready  input / output  1 / 1  load/store write request handshake.
REQ-010 ls_wreq_addr / ls_wreq_data  input  ADDR_W / 32  write address and data.
REQ-011 if_rsp_valid / ls_rsp_valid  output  1 each  read-data-return strobe per port.
REQ-012 rsp_data  output  32  returned read data, shared by both ports.
REQ-013 arbiter  modport ArbiterControllerIF.Arbiter  drives raddr_valid, raddr, waddr_valid, waddr, wdata; receives rdata.

Function
REQ-014 A request SHALL be accepted on a cycle where its valid and ready are both high; at most one read and one write SHALL be accepted per cycle.
REQ-015 Ready SHALL depend combinationally on valids and internal state, and SHALL NOT feed back into any valid.
REQ-016 An accepted read SHALL drive raddr_valid=1 and raddr=the request address in the same cycle; an accepted write SHALL drive waddr_valid, waddr, and wdata in the same cycle.
REQ-017 With both read ports valid, exactly one port SHALL be granted, according to REQ-027/REQ-028; the loser's ready SHALL be 0.
REQ-018 Hazard: a read SHALL NOT be granted if addr[ADDR_W-1:2] equals the address of the write accepted this cycle or the write accepted in the previous cycle; the write SHALL proceed and the read SHALL stall.
REQ-019 The owner (IF or LS) of each issued read SHALL be tracked in an RD_LAT-deep shift pipeline.
REQ-020 Exactly RD_LAT cycles after issue, the owner's rsp_valid SHALL pulse for one cycle with rsp_data=arbiter.rdata; the other port's rsp_valid SHALL be 0.
REQ-021 Back-to-back reads SHALL issue every cycle; responses SHALL return in issue order.
REQ-022 Responses SHALL have no backpressure; a requester SHALL always sink rsp_valid.
REQ-023 Idle cycles SHALL drive raddr_valid=0 and waddr_valid=0; raddr, waddr, and wdata SHALL hold their last value.

Reset
REQ-024 While rst=0: all ready outputs, both rsp_valid, raddr_valid, and waddr_valid SHALL be 0; the owner pipeline SHALL be cleared; the last-write-address valid flag SHALL be 0; the round-robin pointer SHALL point to IF.
REQ-025 Reads in flight when reset asserts SHALL be dropped with no response after deassertion.
REQ-026 The first request SHALL be acceptable on the first rising edge after deassertion.

Configuration
REQ-027 With ARB_RR_EN defined, read grant SHALL be round-robin: the pointer flips to the other port after each granted read whenever both were valid, and is unchanged when only one port was valid.
REQ-028 Without ARB_RR_EN, read grant SHALL be fixed priority with LS over IF, and there SHALL be no pointer state.

Verification
REQ-029 IF reads 0x100 at t0 -> raddr_valid=1, raddr=0x100 at t0; if_rsp_valid=1 with rsp_data=memory[0x100] at t0+2; ls_rsp_valid=0 throughout.
REQ-030 Both ports read continuously for 6 cycles with ARB_RR_EN defined -> grants IF,LS,IF,LS,IF,LS; without ARB_RR_EN -> LS granted all 6 cycles and IF ready=0.
REQ-031 Write 0x200=0xDEADBEEF at t0 and IF read 0x200 at t0 -> read stalls at t0 and t0+1, issues at t0+2, response at t0+4 returns 0xDEADBEEF.
REQ-032 Write 0x204 and read 0x200 in the same cycle -> both issue that cycle with no stall.
REQ-033 Two reads issued, then rst asserted at t0+1 for 1 cycle -> no rsp_valid after deassertion; a new read then returns normally after 2 cycles.
REQ-034 Reads issued on 10 consecutive cycles alternating owners -> 10 responses in order, each with the correct owner strobe.

Source files
------------

// File: rtl/mem_request_arbiter_if.sv
// Arbiter-to-cache-controller bus: one read-address channel with fixed-latency
// read data, and one write channel.
interface ArbiterControllerIF #(parameter int ADDR_W = 32);
    logic              raddr_valid;
    logic [ADDR_W-1:0] raddr;
    logic              waddr_valid;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport Arbiter (
        output raddr_valid, raddr, waddr_valid, waddr, wdata,
        input  rdata
    );

    modport Controller (
        input  raddr_valid, raddr, waddr_valid, waddr, wdata,
        output rdata
    );
endinterface

// File: rtl/mem_request_arbiter.sv
// Arbitrates IF/LS reads and LS writes onto one cache controller port and
// routes fixed-latency read data back. Define ARB_RR_EN for round-robin reads.
module mem_request_arbiter #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_rreq_valid,
    output logic              if_rreq_ready,
    input  logic [ADDR_W-1:0] if_rreq_addr,
    input  logic              ls_rreq_valid,
    output logic              ls_rreq_ready,
    input  logic [ADDR_W-1:0] ls_rreq_addr,
    input  logic              ls_wreq_valid,
    output logic              ls_wreq_ready,
    input  logic [ADDR_W-1:0] ls_wreq_addr,
    input  logic [31:0]       ls_wreq_data,
    output logic              if_rsp_valid,
    output logic              ls_rsp_valid,
    output logic [31:0]       rsp_data,
    ArbiterControllerIF.Arbiter arbiter
);
    logic              w_acc, lw_vld;
    logic [ADDR_W-3:0] lw_word;
    logic              if_haz, ls_haz, if_ok, ls_ok;
    logic              gnt_if, gnt_ls, r_issue;
    logic [ADDR_W-1:0] r_sel, raddr_q, waddr_q;
    logic [31:0]       wdata_q;
    logic [RD_LAT:1]   vld_pipe, own_pipe;

    // Writes never stall; only reset withholds ready.
    assign ls_wreq_ready = rst;
    assign w_acc         = rst & ls_wreq_valid;

    // A read must not overtake a write to the same word still on its way in.
    assign if_haz = (w_acc  && (if_rreq_addr[ADDR_W-1:2] == ls_wreq_addr[ADDR_W-1:2])) ||
                    (lw_vld && (if_rreq_addr[ADDR_W-1:2] == lw_word));
    assign ls_haz = (w_acc  && (ls_rreq_addr[ADDR_W-1:2] == ls_wreq_addr[ADDR_W-1:2])) ||
                    (lw_vld && (ls_rreq_addr[ADDR_W-1:2] == lw_word));
    assign if_ok  = rst & if_rreq_valid & ~if_haz;
    assign ls_ok  = rst & ls_rreq_valid & ~ls_haz;

`ifdef ARB_RR_EN
    logic ls_turn;
    assign gnt_ls = ls_ok & (~if_ok | ls_turn);
    assign gnt_if = if_ok & ~gnt_ls;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ls_turn <= 1'b0;
        else if (r_issue && if_rreq_valid && ls_rreq_valid)
            ls_turn <= gnt_if;
    end
`else
    assign gnt_ls = ls_ok;
    assign gnt_if = if_ok & ~ls_ok;
`endif

    assign if_rreq_ready = gnt_if;
    assign ls_rreq_ready = gnt_ls;
    assign r_issue       = gnt_if | gnt_ls;
    assign r_sel         = gnt_ls ? ls_rreq_addr : if_rreq_addr;

    assign arbiter.raddr_valid = r_issue;
    assign arbiter.raddr       = r_issue ? r_sel : raddr_q;
    assign arbiter.waddr_valid = w_acc;
    assign arbiter.waddr       = w_acc ? ls_wreq_addr : waddr_q;
    assign arbiter.wdata       = w_acc ? ls_wreq_data : wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lw_vld   <= 1'b0;
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            lw_vld      <= w_acc;
            vld_pipe[1] <= r_issue;
            own_pipe[1] <= gnt_ls;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                own_pipe[k] <= own_pipe[k-1];
            end
        end
    end

    // Bus payloads hold across idle cycles and reset; no reset needed.
    always_ff @(posedge clk) begin
        lw_word <= ls_wreq_addr[ADDR_W-1:2];
        if (r_issue) raddr_q <= r_sel;
        if (w_acc) begin
            waddr_q <= ls_wreq_addr;
            wdata_q <= ls_wreq_data;
        end
    end

    assign if_rsp_valid = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
    assign ls_rsp_valid = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];
    assign rsp_data     = arbiter.rdata;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_mem_request_arbiter;
    localparam int RD_LAT = 2;
    localparam int AW     = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifv, lsv, wv;
    logic [AW-1:0] ifa, lsa, wa;
    logic [31:0]   wd;
    logic          if_rdy, ls_rdy, w_rdy, if_rsp, ls_rsp;
    logic [31:0]   rsp_data;

    always #5 clk = ~clk;

    ArbiterControllerIF #(.ADDR_W(AW)) bus ();

    mem_request_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_rreq_valid(ifv), .if_rreq_ready(if_rdy), .if_rreq_addr(ifa),
        .ls_rreq_valid(lsv), .ls_rreq_ready(ls_rdy), .ls_rreq_addr(lsa),
        .ls_wreq_valid(wv), .ls_wreq_ready(w_rdy), .ls_wreq_addr(wa), .ls_wreq_data(wd),
        .if_rsp_valid(if_rsp), .ls_rsp_valid(ls_rsp), .rsp_data(rsp_data),
        .arbiter(bus)
    );

    // Cache controller model: fixed-latency memory.
    logic [31:0] mem [256];
    logic [31:0] rq  [RD_LAT];
    assign bus.rdata = rq[RD_LAT-1];
    always @(posedge clk) begin
        for (int k = RD_LAT-1; k > 0; k--) rq[k] <= rq[k-1];
        rq[0] <= mem[bus.raddr[9:2]];
        if (bus.waddr_valid) mem[bus.waddr[9:2]] <= bus.wdata;
    end

    // Reference model state
    typedef struct { logic own_ls; logic [31:0] data; int due; } rsp_t;
    rsp_t        q[$];
    logic [31:0] ref_mem [256];
    int          cyc;
    logic        plw_v, ls_turn, has_ra, has_w;
    logic [29:0] plw;
    logic [31:0] last_ra, last_wa, last_wd;
    int          total, bad;

    // Sampled each step for directed sequences
    logic        g_if, g_ls, s_if_rsp, s_ls_rsp;
    logic [31:0] s_data;

    typedef struct {
        logic ifv; logic [31:0] ifa; logic lsv; logic [31:0] lsa;
        logic wv;  logic [31:0] wa;
        logic e_if; logic e_ls; logic [31:0] e_ra;
    } vec_t;
    vec_t vecs[12];
    vec_t tv;
    logic tv_en;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic haz(input logic [31:0] a);
        return (rst && wv && (a[31:2] == wa[31:2])) || (plw_v && (a[31:2] == plw));
    endfunction

    // One clock: check outputs at negedge against the model, advance the model.
    task automatic step();
        logic eif, els, gif, gls, wve, ev_if, ev_ls;
        logic [31:0] ra, ed;
        @(negedge clk);
        if (!rst) begin q.delete(); plw_v = 1'b0; ls_turn = 1'b0; end
        eif = rst && ifv && !haz(ifa);
        els = rst && lsv && !haz(lsa);
        if (eif && els) begin
`ifdef ARB_RR_EN
            gls = ls_turn;
`else
            gls = 1'b1;
`endif
            gif = !gls;
        end else begin
            gif = eif; gls = els;
        end
        wve = rst && wv;
        chk("if_ready", {31'b0, if_rdy}, {31'b0, gif});
        chk("ls_ready", {31'b0, ls_rdy}, {31'b0, gls});
        chk("w_ready", {31'b0, w_rdy}, {31'b0, rst});
        chk("raddr_valid", {31'b0, bus.raddr_valid}, {31'b0, gif | gls});
        if (gif | gls) chk("raddr", bus.raddr, gls ? lsa : ifa);
        else if (has_ra) chk("raddr_hold", bus.raddr, last_ra);
        chk("waddr_valid", {31'b0, bus.waddr_valid}, {31'b0, wve});
        if (wve) begin
            chk("waddr", bus.waddr, wa);
            chk("wdata", bus.wdata, wd);
        end else if (has_w) begin
            chk("waddr_hold", bus.waddr, last_wa);
            chk("wdata_hold", bus.wdata, last_wd);
        end
        ev_if = 1'b0; ev_ls = 1'b0; ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev_if = !q[0].own_ls; ev_ls = q[0].own_ls; ed = q[0].data;
            void'(q.pop_front());
        end
        chk("if_rsp_valid", {31'b0, if_rsp}, {31'b0, ev_if});
        chk("ls_rsp_valid", {31'b0, ls_rsp}, {31'b0, ev_ls});
        if (ev_if | ev_ls) chk("rsp_data", rsp_data, ed);
        if (tv_en) begin
            chk("tbl_if_ready", {31'b0, if_rdy}, {31'b0, tv.e_if});
            chk("tbl_ls_ready", {31'b0, ls_rdy}, {31'b0, tv.e_ls});
            if (tv.e_if | tv.e_ls) chk("tbl_raddr", bus.raddr, tv.e_ra);
        end
        g_if = if_rdy; g_ls = ls_rdy; s_if_rsp = if_rsp; s_ls_rsp = ls_rsp; s_data = rsp_data;
        @(posedge clk);
        if (gif | gls) begin
            ra = gls ? lsa : ifa;
            q.push_back('{gls, ref_mem[ra[9:2]], cyc + RD_LAT});
            last_ra = ra; has_ra = 1'b1;
            if (ifv && lsv) ls_turn = gif;
        end
        if (wve) begin
            ref_mem[wa[9:2]] = wd;
            last_wa = wa; last_wd = wd; has_w = 1'b1;
        end
        plw_v = wve; plw = wa[31:2];
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        ifv = 1'b0; lsv = 1'b0; wv = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n_if, n_ls, alt_ok, got_at, nrsp;
        total = 0; bad = 0; cyc = 0; tv_en = 1'b0;
        plw_v = 1'b0; plw = '0; ls_turn = 1'b0; has_ra = 1'b0; has_w = 1'b0;
        last_ra = '0; last_wa = '0; last_wd = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 ^ (i * 32'h0101_0101);
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
        end
        for (int k = 0; k < RD_LAT; k++) rq[k] = '0;
        rst = 1'b0; ifv = 1'b0; lsv = 1'b0; wv = 1'b0;
        ifa = '0; lsa = '0; wa = '0; wd = '0;

        vecs[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h100};
        vecs[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 32'h140, 1'b0, 32'h0,   1'b0, 1'b1, 32'h140};
`ifdef ARB_RR_EN
        vecs[4]  = '{1'b1, 32'h180, 1'b1, 32'h1C0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h180};
`else
        vecs[4]  = '{1'b1, 32'h180, 1'b1, 32'h1C0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1C0};
`endif
        vecs[5]  = '{1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 1'b0, 32'h200};
        vecs[6]  = '{1'b1, 32'h204, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h204, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h204};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h080, 1'b1, 32'h0C0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0C0};
        vecs[11] = '{1'b1, 32'h0C4, 1'b1, 32'h0C8, 1'b1, 32'h0C4, 1'b0, 1'b1, 32'h0C8};

        // Reset state
        step();
        rst = 1'b1;

        // Vector table, starting on the first edge after reset release
        for (int i = 0; i < 12; i++) begin
            ifv = vecs[i].ifv; ifa = vecs[i].ifa; lsv = vecs[i].lsv; lsa = vecs[i].lsa;
            wv = vecs[i].wv; wa = vecs[i].wa; wd = 32'h1000 + i;
            tv = vecs[i]; tv_en = 1'b1;
            step();
            tv_en = 1'b0;
        end
        idle(3);

        // Both ports continuously valid for 6 cycles
        n_if = 0; n_ls = 0; alt_ok = 1;
        ifv = 1'b1; ifa = 32'h010; lsv = 1'b1; lsa = 32'h020;
        for (int i = 0; i < 6; i++) begin
            logic prev_if;
            prev_if = g_if;
            step();
            n_if += int'(g_if); n_ls += int'(g_ls);
            if (i > 0 && g_if == prev_if) alt_ok = 0;
        end
`ifdef ARB_RR_EN
        chk("rr_if_grants", n_if, 3);
        chk("rr_alternate", alt_ok, 1);
`else
        chk("fixed_if_grants", n_if, 0);
        chk("fixed_ls_grants", n_ls, 6);
`endif
        idle(3);

        // Same-word write and read: read stalls two cycles then sees new data
        wv = 1'b1; wa = 32'h200; wd = 32'hDEADBEEF; ifv = 1'b1; ifa = 32'h200;
        step(); chk("raw_stall_t0", {31'b0, g_if}, 32'd0);
        wv = 1'b0;
        step(); chk("raw_stall_t1", {31'b0, g_if}, 32'd0);
        step(); chk("raw_issue_t2", {31'b0, g_if}, 32'd1);
        ifv = 1'b0;
        got_at = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_if_rsp && got_at < 0) begin
                got_at = k;
                chk("raw_data", s_data, 32'hDEADBEEF);
            end
        end
        chk("raw_rsp_cycle", got_at, 1);

        // Reset with reads in flight drops them
        ifv = 1'b1; ifa = 32'h040; step();
        ifa = 32'h044; step();
        ifv = 1'b0; rst = 1'b0; step();
        rst = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            nrsp += int'(s_if_rsp) + int'(s_ls_rsp);
        end
        chk("dropped_after_reset", nrsp, 0);
        ifv = 1'b1; ifa = 32'h048; step();
        ifv = 1'b0; step(); step();
        chk("post_reset_rsp", {31'b0, s_if_rsp}, 32'd1);
        chk("post_reset_data", s_data, ref_mem[8'h12]);

        // Ten back-to-back reads alternating owners
        nrsp = 0;
        for (int i = 0; i < 10 + RD_LAT + 1; i++) begin
            ifv = (i < 10) && (i % 2 == 0); ifa = 32'h100 + 32'(i * 4);
            lsv = (i < 10) && (i % 2 == 1); lsa = 32'h180 + 32'(i * 4);
            step();
            nrsp += int'(s_if_rsp) + int'(s_ls_rsp);
        end
        chk("b2b_rsp_count", nrsp, 10);

        // Random traffic over a small address window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            ifv = ($urandom % 4) != 0; ifa = 32'($urandom_range(0, 15)) << 2;
            lsv = ($urandom % 4) != 0; lsa = 32'($urandom_range(0, 15)) << 2;
            wv  = ($urandom % 3) == 0; wa  = 32'($urandom_range(0, 15)) << 2;
            wd  = $urandom;
            rst = ($urandom % 100) != 0;
            step();
        end
        rst = 1'b1;
        idle(RD_LAT + 2);
        chk("model_queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
